// File: rtl/mem_access_responder.sv
// rtl/mem_access_responder.sv - single-outstanding request/response bridge onto an Avalon-MM master
module mem_access_responder #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] mem_access_req_data,
    input  logic         mem_access_req_valid,
    output logic         mem_access_req_ready,
    output logic [127:0] mem_access_resp_data,
    output logic         mem_access_resp_valid,
    input  logic         mem_access_resp_ready,
    output logic [31:0]  avm_address,
    output logic         avm_read,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    output logic [3:0]   avm_byteenable,
    input  logic         avm_waitrequest,
    input  logic [31:0]  avm_readdata,
    input  logic         avm_readdatavalid,
    input  logic [1:0]   avm_response,
    output logic [15:0]  stat_timeouts
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state, next_state;

    logic          req_ready_r;
    logic          req_is_write;
    logic [7:0]    req_tag;
    logic [3:0]    req_be;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [CW-1:0] tmo_cnt;
    logic [15:0]   tmo_stat;

    logic accept;
    logic timeout_hit;
    logic abort;

    // Fields the request format leaves undefined; reduced here only to document they are dropped.
    logic unused_req_bits;
    assign unused_req_bits = ^{mem_access_req_data[126:120], mem_access_req_data[111:100],
                               mem_access_req_data[63:32]};

    assign accept      = (state == IDLE) && req_ready_r && mem_access_req_valid;
    assign timeout_hit = (tmo_cnt == TMO_LAST);

    // Completion beats timeout: abort only when the cycle did not also finish the step.
    assign abort = timeout_hit &&
                   (((state == CMD) && avm_waitrequest) ||
                    ((state == WAIT_RD) && !avm_readdatavalid));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = CMD;
                end
            end
            CMD: begin
                if (!avm_waitrequest) begin
                    next_state = req_is_write ? IDLE : WAIT_RD;
                end else if (timeout_hit) begin
                    next_state = req_is_write ? IDLE : RESP;
                end
            end
            WAIT_RD: begin
                if (avm_readdatavalid || timeout_hit) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (mem_access_resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        avm_read              = 1'b0;
        avm_write             = 1'b0;
        mem_access_resp_valid = 1'b0;
        case (state)
            CMD: begin
                avm_read  = !req_is_write;
                avm_write = req_is_write;
            end
            RESP:    mem_access_resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready_r  <= 1'b0;
            req_is_write <= 1'b0;
            req_tag      <= 8'h00;
            req_be       <= 4'h0;
            req_addr     <= 32'h0;
            req_wdata    <= 32'h0;
            resp_rdata   <= 32'h0;
            resp_err     <= 1'b0;
            tmo_cnt      <= '0;
            tmo_stat     <= 16'h0;
        end else begin
            // Ready is a registered decode of the state we are about to enter.
            req_ready_r <= (next_state == IDLE);

            if (accept) begin
                req_is_write <= mem_access_req_data[127];
                req_tag      <= mem_access_req_data[119:112];
                req_be       <= mem_access_req_data[99:96];
                req_addr     <= mem_access_req_data[95:64];
                req_wdata    <= mem_access_req_data[31:0];
                tmo_cnt      <= '0;
            end else if ((state == CMD) || (state == WAIT_RD)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if ((state == WAIT_RD) && avm_readdatavalid) begin
                resp_rdata <= avm_readdata;
                resp_err   <= (avm_response != 2'b00);
            end else if (abort && !req_is_write) begin
                resp_rdata <= 32'hFFFF_FFFF;
                resp_err   <= 1'b1;
            end

            if (abort && (tmo_stat != 16'hFFFF)) begin
                tmo_stat <= tmo_stat + 16'h1;
            end
        end
    end

    assign mem_access_req_ready = req_ready_r;
    assign avm_address          = {req_addr[31:2], 2'b00};
    assign avm_writedata        = req_wdata;
    assign avm_byteenable       = req_be;
    assign stat_timeouts        = tmo_stat;
    assign mem_access_resp_data = {8'h00, req_tag, 15'h0000, resp_err, 64'h0, resp_rdata};

endmodule

// File: tb/tb_mem_access_responder.sv
// tb/tb_mem_access_responder.sv - directed self-checking bench for mem_access_responder
`timescale 1ns/1ps
module tb_mem_access_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] mem_access_req_data;
    logic         mem_access_req_valid;
    logic         mem_access_req_ready;
    logic [127:0] mem_access_resp_data;
    logic         mem_access_resp_valid;
    logic         mem_access_resp_ready;
    logic [31:0]  avm_address;
    logic         avm_read;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic [3:0]   avm_byteenable;
    logic         avm_waitrequest;
    logic [31:0]  avm_readdata;
    logic         avm_readdatavalid;
    logic [1:0]   avm_response;
    logic [15:0]  stat_timeouts;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_responder #(.TIMEOUT_CYCLES(16)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .mem_access_req_data   (mem_access_req_data),
        .mem_access_req_valid  (mem_access_req_valid),
        .mem_access_req_ready  (mem_access_req_ready),
        .mem_access_resp_data  (mem_access_resp_data),
        .mem_access_resp_valid (mem_access_resp_valid),
        .mem_access_resp_ready (mem_access_resp_ready),
        .avm_address           (avm_address),
        .avm_read              (avm_read),
        .avm_write             (avm_write),
        .avm_writedata         (avm_writedata),
        .avm_byteenable        (avm_byteenable),
        .avm_waitrequest       (avm_waitrequest),
        .avm_readdata          (avm_readdata),
        .avm_readdatavalid     (avm_readdatavalid),
        .avm_response          (avm_response),
        .stat_timeouts         (stat_timeouts)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_req(input logic wr, input logic [7:0] tag,
                                            input logic [3:0] be, input logic [31:0] addr,
                                            input logic [31:0] wd, input logic [31:0] junk);
        return {wr, 7'h55, tag, 12'hABC, be, addr, junk, wd};
    endfunction

    function automatic logic [127:0] mk_resp(input logic [7:0] tag, input logic err,
                                             input logic [31:0] rd);
        return {8'h00, tag, 15'h0000, err, 64'h0, rd};
    endfunction

    // Presents a request in the cycle ready is seen; returns at cycle N+1.
    task automatic issue(input logic [127:0] req);
        int n;
        n = 0;
        while (!mem_access_req_ready && n < 20) begin
            tick;
            n++;
        end
        chk("issue_ready_seen", mem_access_req_ready, 1'b1);
        mem_access_req_data  = req;
        mem_access_req_valid = 1'b1;
        tick;
        mem_access_req_valid = 1'b0;
        mem_access_req_data  = '0;
    endtask

    initial begin
        int k;
        reset                 = 1'b1;
        mem_access_req_data   = '0;
        mem_access_req_valid  = 1'b0;
        mem_access_resp_ready = 1'b1;
        avm_waitrequest       = 1'b0;
        avm_readdata          = 32'h0;
        avm_readdatavalid     = 1'b0;
        avm_response          = 2'b00;

        tick;
        tick;
        chk("rst_req_ready", mem_access_req_ready, 1'b0);
        chk("rst_resp_valid", mem_access_resp_valid, 1'b0);
        chk("rst_avm_read", avm_read, 1'b0);
        chk("rst_avm_write", avm_write, 1'b0);
        chk("rst_stat", stat_timeouts, 16'h0);
        chk("rst_resp_data", mem_access_resp_data, 128'h0);
        reset = 1'b0;
        tick;
        chk("post_rst_req_ready", mem_access_req_ready, 1'b1);

        // Zero-wait read: avm_read at N+1, readdatavalid at N+2, resp at N+3.
        issue(mk_req(1'b0, 8'h5A, 4'hF, 32'h0000_0010, 32'h0, 32'hA5A5_A5A5));
        chk("rd_avm_read_n1", avm_read, 1'b1);
        chk("rd_avm_write_n1", avm_write, 1'b0);
        chk("rd_addr_n1", avm_address, 32'h0000_0010);
        chk("rd_req_ready_n1", mem_access_req_ready, 1'b0);
        tick;
        chk("rd_avm_read_n2", avm_read, 1'b0);
        chk("rd_resp_valid_n2", mem_access_resp_valid, 1'b0);
        avm_readdatavalid     = 1'b1;
        avm_readdata          = 32'hDEAD_BEEF;
        avm_response          = 2'b00;
        mem_access_resp_ready = 1'b0;
        tick;
        avm_readdatavalid = 1'b0;
        chk("rd_resp_valid_n3", mem_access_resp_valid, 1'b1);
        chk("rd_resp_data", mem_access_resp_data, mk_resp(8'h5A, 1'b0, 32'hDEAD_BEEF));
        mem_access_resp_ready = 1'b1;
        tick;
        chk("rd_resp_valid_done", mem_access_resp_valid, 1'b0);
        chk("rd_req_ready_done", mem_access_req_ready, 1'b1);

        // Posted write with waitrequest high for the first three command cycles.
        avm_waitrequest = 1'b1;
        issue(mk_req(1'b1, 8'h33, 4'b0011, 32'h0000_0023, 32'h1234_5678, 32'h0));
        for (int i = 0; i < 4; i++) begin
            chk("wr_avm_write_held", avm_write, 1'b1);
            chk("wr_addr", avm_address, 32'h0000_0020);
            chk("wr_wdata", avm_writedata, 32'h1234_5678);
            chk("wr_be", avm_byteenable, 4'b0011);
            chk("wr_no_resp", mem_access_resp_valid, 1'b0);
            if (i == 3) avm_waitrequest = 1'b0;
            tick;
        end
        chk("wr_avm_write_drop", avm_write, 1'b0);
        chk("wr_req_ready_after", mem_access_req_ready, 1'b1);
        chk("wr_no_resp_after", mem_access_resp_valid, 1'b0);
        tick;
        chk("wr_no_resp_later", mem_access_resp_valid, 1'b0);

        // Read with no readdatavalid: abort after the counter reaches 15.
        issue(mk_req(1'b0, 8'h11, 4'hF, 32'h0000_0100, 32'h0, 32'h0));
        k = 1;
        while (!mem_access_resp_valid && k < 40) begin
            tick;
            k++;
        end
        chk("tmo_resp_cycle", k, 17);
        chk("tmo_resp_data", mem_access_resp_data, mk_resp(8'h11, 1'b1, 32'hFFFF_FFFF));
        chk("tmo_stat", stat_timeouts, 16'h1);
        tick;
        chk("tmo_resp_valid_done", mem_access_resp_valid, 1'b0);
        chk("tmo_req_ready_done", mem_access_req_ready, 1'b1);

        // Response backpressure for ten cycles.
        mem_access_resp_ready = 1'b0;
        issue(mk_req(1'b0, 8'h77, 4'hF, 32'h0000_0044, 32'h0, 32'h0));
        tick;
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hCAFE_F00D;
        avm_response      = 2'b00;
        tick;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'h0;
        mem_access_req_data  = mk_req(1'b0, 8'h99, 4'hF, 32'h0000_0080, 32'h0, 32'h0);
        mem_access_req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("stall_resp_valid", mem_access_resp_valid, 1'b1);
            chk("stall_resp_data", mem_access_resp_data, mk_resp(8'h77, 1'b0, 32'hCAFE_F00D));
            chk("stall_req_ready", mem_access_req_ready, 1'b0);
            tick;
        end
        mem_access_req_valid  = 1'b0;
        mem_access_resp_ready = 1'b1;
        tick;
        chk("stall_resp_valid_done", mem_access_resp_valid, 1'b0);
        chk("stall_req_ready_done", mem_access_req_ready, 1'b1);
        chk("stall_no_cmd", avm_read, 1'b0);

        // Slave error response: error flag set, data passed through.
        issue(mk_req(1'b0, 8'h3C, 4'hF, 32'h0000_0200, 32'h0, 32'h0));
        tick;
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h0BAD_F00D;
        avm_response      = 2'b10;
        tick;
        avm_readdatavalid = 1'b0;
        avm_response      = 2'b00;
        chk("err_resp_valid", mem_access_resp_valid, 1'b1);
        chk("err_resp_data", mem_access_resp_data, mk_resp(8'h3C, 1'b1, 32'h0BAD_F00D));
        tick;
        chk("err_resp_valid_done", mem_access_resp_valid, 1'b0);

        // Reset in WAIT_RD followed by a late readdatavalid.
        issue(mk_req(1'b0, 8'h66, 4'hF, 32'h0000_0300, 32'h0, 32'h0));
        tick;
        chk("rst_mid_in_wait", avm_read, 1'b0);
        reset = 1'b1;
        tick;
        chk("rst_mid_req_ready", mem_access_req_ready, 1'b0);
        chk("rst_mid_resp_valid", mem_access_resp_valid, 1'b0);
        reset = 1'b0;
        tick;
        chk("rst_mid_ready_after", mem_access_req_ready, 1'b1);
        chk("rst_mid_stat_clear", stat_timeouts, 16'h0);
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h1357_9BDF;
        tick;
        avm_readdatavalid = 1'b0;
        chk("late_rdv_no_resp", mem_access_resp_valid, 1'b0);
        chk("late_rdv_ready", mem_access_req_ready, 1'b1);
        tick;
        chk("late_rdv_no_resp2", mem_access_resp_valid, 1'b0);
        chk("late_rdv_data_clear", mem_access_resp_data, 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
